fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage upstream of decode/control_unit: holds PC, issues imem requests,
//  delivers {pc, instr} through IF/ID register to decode. Applies redirects (branch/jump/jr)
//  from later stages, honours decode stall, discards stale imem responses after redirect.
// PARAMETERS
//  ADDR_W    16       PC / imem address width
//  INSTR_W   16       instruction width (opcode[15:12], funct[2:0])
//  RESET_PC  16'h0000 PC loaded on reset
//  PC_INC    2        PC increment per instruction (byte addressed)
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        synchronous reset, active-high
//  imem_req       out  1        request valid; held until imem_ready
//  imem_addr      out  ADDR_W   fetch address (=pc); stable while imem_req high
//  imem_ready     in   1        request accepted this cycle
//  imem_rvalid    in   1        response valid, >=1 cycle after acceptance, in order
//  imem_rdata     in   INSTR_W  response instruction
//  stall          in   1        decode cannot accept; hold if_id outputs
//  redirect       in   1        taken branch/jump/jr; highest priority
//  redirect_pc    in   ADDR_W   new fetch address
//  if_id_valid    out  1        if_id_instr/if_id_pc valid for decode
//  if_id_instr    out  INSTR_W  fetched instruction
//  if_id_pc       out  ADDR_W   address of if_id_instr
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=FETCH, imem_req=0, if_id_valid=0, if_id_instr=0, if_id_pc=0, skid empty.
//  Max one outstanding request. Handshake: request transfers when imem_req&imem_ready.
//  FETCH: imem_req=1 unless skid full; on transfer -> WAIT, pc+=PC_INC (wraps mod 2^ADDR_W).
//  WAIT: imem_req=0; on imem_rvalid: if !if_id_valid | !stall load if_id, -> FETCH;
//        else capture into skid -> HOLD.
//  HOLD: imem_req=0; when !stall skid moves to if_id, skid empties -> FETCH.
//  DRAIN: imem_req=0; on imem_rvalid drop response -> FETCH.
//  if_id_valid clears when consumed (!stall) and no new data loaded same cycle.
//  Redirect (any state, overrides stall): pc=redirect_pc; if_id_valid=0; skid emptied;
//   WAIT without rvalid this cycle -> DRAIN; WAIT with rvalid -> response dropped, FETCH;
//   FETCH with request transfer same cycle -> DRAIN (request issued for old pc); else FETCH.
//   Redirect in DRAIN: pc updated, stay DRAIN.
//  Latency: request accept -> if_id_valid one cycle after rvalid. Zero-bubble not required.
//  rst mid-transaction: return to reset state; a pending rvalid after reset is ignored
//   (state FETCH ignores rvalid).
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_fetched[31:0] (increments per if_id load)
//   and perf_stall_cyc[31:0] (increments each cycle if_id_valid&stall); both reset to 0,
//   saturate at all-ones. Undefined: ports and counters absent; no other change.
// STRUCTURE
//  defines.v: FS_FETCH/FS_WAIT/FS_HOLD/FS_DRAIN 2-bit encodings, INSTR_W/ADDR_W defaults,
//   RESET_PC constant.
//  Sub-module if_id_reg: if_id output register + 1-entry skid buffer with load/consume/flush.
// TESTING
//  Reset, imem_ready=1, rvalid 1 cycle later -> addrs 0x0000,0x0002,0x0004; if_id_pc matches.
//  stall held 3 cycles with rvalid pending -> HOLD; if_id stable; next instr emerges after release, none lost.
//  redirect to 0x0040 while WAIT -> DRAIN; stale rdata dropped; next imem_addr=0x0040.
//  redirect and rvalid same cycle -> response dropped, if_id_valid=0, fetch 0x0040 next.
//  pc=0xFFFE fetch -> next imem_addr=0x0000 (wrap).
//  rst asserted in WAIT -> outputs zero next cycle; subsequent rvalid ignored; fetch RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - fetch stage state encodings and default widths/constants
package fetch_stage_pkg;

  localparam int unsigned FS_ADDR_W   = 16;
  localparam int unsigned FS_INSTR_W  = 16;
  localparam logic [15:0] FS_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_WAIT  = 2'd1,
    FS_HOLD  = 2'd2,
    FS_DRAIN = 2'd3
  } fs_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID output register with a one-entry skid buffer
module fetch_stage_if_id_reg #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [INSTR_W-1:0] load_instr_i,
  input  logic [ADDR_W-1:0]  load_pc_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               skid_full_o,
  output logic               loaded_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;

  always_comb begin
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    loaded_o     = 1'b0;
    if (flush_i) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q && !stall_i) begin
      valid_d      = 1'b1;
      instr_d      = skid_instr_q;
      pc_d         = skid_pc_q;
      skid_valid_d = 1'b0;
      loaded_o     = 1'b1;
    end else if (load_i && (!valid_q || !stall_i)) begin
      valid_d  = 1'b1;
      instr_d  = load_instr_i;
      pc_d     = load_pc_i;
      loaded_o = 1'b1;
    end else if (load_i) begin
      // Decode is stalled on a valid entry: park the response rather than lose it.
      skid_valid_d = 1'b1;
      skid_instr_d = load_instr_i;
      skid_pc_d    = load_pc_i;
    end else if (!stall_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      instr_q      <= '0;
      pc_q         <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign valid_o     = valid_q;
  assign instr_o     = instr_q;
  assign pc_o        = pc_q;
  assign skid_full_o = skid_valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem request FSM, redirect and stall handling
// Optional perf counters perf_fetched/perf_stall_cyc when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned        ADDR_W   = FS_ADDR_W,
  parameter int unsigned        INSTR_W  = FS_INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(FS_RESET_PC),
  parameter int unsigned        PC_INC   = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall_cyc
`endif
);

  fs_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              req_c;
  logic              xfer;
  logic              load;
  logic              skid_full;
  logic              if_loaded;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    req_c    = 1'b0;
    xfer     = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      FS_FETCH: begin
        req_c = !skid_full;
        xfer  = req_c && imem_ready;
        if (xfer) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + ADDR_W'(PC_INC);
          state_d  = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (imem_rvalid) begin
          load    = 1'b1;
          state_d = (!if_id_valid || !stall) ? FS_FETCH : FS_HOLD;
        end
      end
      FS_HOLD: begin
        if (!stall) state_d = FS_FETCH;
      end
      FS_DRAIN: begin
        if (imem_rvalid) state_d = FS_FETCH;
      end
    endcase
    if (redirect) begin
      pc_d = redirect_pc;
      load = 1'b0;
      unique case (state_q)
        FS_FETCH: state_d = xfer ? FS_DRAIN : FS_FETCH;
        FS_WAIT:  state_d = imem_rvalid ? FS_FETCH : FS_DRAIN;
        FS_HOLD:  state_d = FS_FETCH;
        // The stale response arriving in the same cycle still retires the drain.
        FS_DRAIN: state_d = imem_rvalid ? FS_FETCH : FS_DRAIN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FS_FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Reset state is FETCH, so the request is masked while rst is held.
  assign imem_req  = req_c && !rst;
  assign imem_addr = pc_q;

  fetch_stage_if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_i       (load),
    .load_instr_i (imem_rdata),
    .load_pc_i    (req_pc_q),
    .stall_i      (stall),
    .flush_i      (redirect),
    .valid_o      (if_id_valid),
    .instr_o      (if_id_instr),
    .pc_o         (if_id_pc),
    .skid_full_o  (skid_full),
    .loaded_o     (if_loaded)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_stall_cyc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q   <= '0;
      perf_stall_cyc_q <= '0;
    end else begin
      if (if_loaded && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (if_id_valid && stall && (perf_stall_cyc_q != '1))
        perf_stall_cyc_q <= perf_stall_cyc_q + 32'd1;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_stall_cyc = perf_stall_cyc_q;
`else
  logic unused_loaded;
  assign unused_loaded = if_loaded;
`endif

endmodule
